mips_datapath_alu_muldiv: RTL and testbench

Iterative multiply/divide unit next to the execute-stage ALU datapath. It takes the same regPort1/regPort2 operands and owns the architectural HI/LO registers. MULT/MULTU use radix-2 shift-add. DIV/DIVU use restoring division. busy stalls the pipeline while an operation runs, and MFHI/MFLO read hi/lo directly.

---
 rtl/mips_datapath_alu_muldiv_if.sv | 25 ++
 rtl/mips_datapath_alu_muldiv.sv | 156 +++++++++++++++
 tb/tb_mips_datapath_alu_muldiv.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_datapath_alu_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface mips_datapath_alu_muldiv_if #(
   parameter int unsigned DATA_W = 32
);
   logic              start;
   logic [2:0]        op;
   logic              cancel;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic              busy;
   logic              done;
   logic              divZero;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, op, cancel, data1, data2,
      input  busy, done, divZero, hi, lo
   );

   modport slave (
      input  start, op, cancel, data1, data2,
      output busy, done, divZero, hi, lo
   );
endinterface

// File: rtl/mips_datapath_alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle with a final sign-fix/commit cycle.
module mips_datapath_alu_muldiv #(
   parameter int unsigned DATA_W = 32
) (
   input logic                      clock,
   input logic                      reset,
   mips_datapath_alu_muldiv_if.slave bus
);
   localparam int unsigned CntW = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic                is_div_q, is_div_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic                dz_q, dz_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic                done_q, done_d;
   logic                dz_out_q, dz_out_d;

   logic                is_signed, sign1, sign2, zero_div;
   logic [DATA_W-1:0]   abs1, abs2;
   logic [DATA_W:0]     add_sum, trial_rem;
   logic [2*DATA_W-1:0] mult_next, div_next, prod_fix;
   logic [DATA_W-1:0]   quot, rem;

   // Most-negative operand negates to itself, which read unsigned is the right magnitude.
   assign is_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
   assign sign1     = is_signed & bus.data1[DATA_W-1];
   assign sign2     = is_signed & bus.data2[DATA_W-1];
   assign abs1      = sign1 ? -bus.data1 : bus.data1;
   assign abs2      = sign2 ? -bus.data2 : bus.data2;
   assign zero_div  = bus.op[1] && (bus.data2 == '0);

   assign add_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
   assign mult_next = acc_q[0] ? {add_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};

   // Remainder is always below the divisor, so its shifted value fits in DATA_W+1 bits.
   assign trial_rem = acc_q[2*DATA_W-1:DATA_W-1];
   assign div_next  = (trial_rem >= {1'b0, opnd_q})
                    ? {DATA_W'(trial_rem - {1'b0, opnd_q}), acc_q[DATA_W-2:0], 1'b1}
                    : {acc_q[2*DATA_W-2:0], 1'b0};

   assign prod_fix  = neg_res_q ? -acc_q : acc_q;
   assign quot      = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem       = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_out_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.cancel) begin
               case (bus.op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     state_d   = zero_div ? StFix : StRun;
                     cnt_d     = CntW'(DATA_W);
                     is_div_d  = bus.op[1];
                     neg_res_d = sign1 ^ sign2;
                     neg_rem_d = sign1;
                     dz_d      = zero_div;
                     if (bus.op[1]) begin
                        acc_d  = {{DATA_W{1'b0}}, zero_div ? bus.data1 : abs1};
                        opnd_d = abs2;
                     end else begin
                        acc_d  = {{DATA_W{1'b0}}, abs2};
                        opnd_d = abs1;
                     end
                  end
                  3'd4:    hi_d = bus.data1;
                  3'd5:    lo_d = bus.data1;
                  default: ;
               endcase
            end
         end
         StRun: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               acc_d = is_div_q ? div_next : mult_next;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!bus.cancel) begin
               done_d   = 1'b1;
               dz_out_d = dz_q;
               if (dz_q) begin
                  hi_d = acc_q[DATA_W-1:0];
                  lo_d = '1;
               end else if (is_div_q) begin
                  hi_d = rem;
                  lo_d = quot;
               end else begin
                  hi_d = prod_fix[2*DATA_W-1:DATA_W];
                  lo_d = prod_fix[DATA_W-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_out_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dz_out_q  <= dz_out_d;
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.done    = done_q;
   assign bus.divZero = dz_out_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_mips_datapath_alu_muldiv.sv
// Directed, table-driven bench for the iterative mul/div unit plus hand-written
// sequences for cancel, back-to-back starts, MTHI/MTLO and reset.
module tb_mips_datapath_alu_muldiv;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mips_datapath_alu_muldiv_if #(.DATA_W(32)) bus ();

   mips_datapath_alu_muldiv #(.DATA_W(32)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one mult/div request; returns edges from acceptance to done and busy cycles seen.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.data1 = a;
      bus.data2 = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 3'd6;
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      lat       = 0;
      busy_cnt  = bus.busy ? 1 : 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.busy) busy_cnt++;
      end
      if (lat == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done within 100 cycles, required a done pulse");
      end
   endtask

   task automatic watch_no_done(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen++;
      end
      check(name, seen, 0);
   endtask

   initial begin
      int lat, bc;

      vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{3'd0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

      bus.start  = 1'b0;
      bus.op     = 3'd6;
      bus.cancel = 1'b0;
      bus.data1  = '0;
      bus.data2  = '0;

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      #1;
      check("reset_hi", bus.hi, 0);
      check("reset_lo", bus.lo, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_divzero", bus.divZero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // op 6 is a no-op.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd6; bus.data1 = 32'hDEAD; bus.data2 = 32'hBEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("op6_busy", bus.busy, 0);
      check("op6_hi", bus.hi, 0);
      check("op6_lo", bus.lo, 0);

      // MTHI / MTLO.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'h1234;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("mthi_hi", bus.hi, 32'h1234);
      check("mthi_busy", bus.busy, 0);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd5; bus.data1 = 32'h5678;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("mtlo_lo", bus.lo, 32'h5678);
      check("mtlo_hi", bus.hi, 32'h1234);
      check("mtlo_done", bus.done, 0);

      // op 7 is a no-op too.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd7; bus.data1 = 32'hAAAA;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("op7_hi", bus.hi, 32'h1234);
      check("op7_lo", bus.lo, 32'h5678);

      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
         check($sformatf("vec%0d_divzero", i), bus.divZero, vecs[i].dz);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].dz ? 1 : 33);
         check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].dz ? 1 : 33);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_done_width", i), bus.done, 0);
         check($sformatf("vec%0d_divzero_clr", i), bus.divZero, 0);
      end

      // Second start while busy is dropped, not queued.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd1; bus.data1 = 32'd2; bus.data2 = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd1; bus.data1 = 32'd5; bus.data2 = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = 1;
            break;
         end
      end
      check("b2b_done_seen", lat, 1);
      check("b2b_lo", bus.lo, 32'd6);
      check("b2b_hi", bus.hi, 32'd0);
      @(posedge clk);
      #1;
      check("b2b_not_queued", bus.busy, 0);

      // New start accepted in the done cycle.
      do_op(3'd1, 32'd4, 32'd5, lat, bc);
      check("chain1_lo", bus.lo, 32'd20);
      do_op(3'd1, 32'd6, 32'd7, lat, bc);
      check("chain2_latency", lat, 33);
      check("chain2_lo", bus.lo, 32'd42);

      // Cancel in RUN keeps hi/lo and suppresses done.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd1; bus.data1 = 32'hFFFFFFFF; bus.data2 = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check("cancel_busy", bus.busy, 0);
      watch_no_done("cancel_no_done", 40);
      check("cancel_hi", bus.hi, 32'd0);
      check("cancel_lo", bus.lo, 32'd42);

      // Cancel beats start in IDLE.
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd4; bus.data1 = 32'hDEAD;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("cancel_idle_hi", bus.hi, 32'd0);
      check("cancel_idle_busy", bus.busy, 0);

      // Reset mid-RUN.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd1; bus.data1 = 32'd9; bus.data2 = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rstrun_busy", bus.busy, 0);
      check("rstrun_hi", bus.hi, 0);
      check("rstrun_lo", bus.lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_done("rstrun_no_done", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
